// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and width helper.
package fifo_arb_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Index width for n items, never less than one bit so NREQ=1 still has a legal vector.
    function automatic int unsigned clog2Min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin search: first active request after RrLast, wrapping modulo NREQ.
module fifo_rr_pick #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned IWIDTH = 1
) (
    input  logic [NREQ-1:0]   Req,
    input  logic [IWIDTH-1:0] RrLast,
    output logic [IWIDTH-1:0] Winner,
    output logic              Valid
);

    always_comb begin
        int unsigned idx;
        Winner = '0;
        Valid  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(RrLast) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!Valid && ((Req >> idx) & NREQ'(1)) != '0) begin
                Winner = IWIDTH'(idx);
                Valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters, in bursts of up to
// BURST_MAX words, with every write gated by the FIFO full flag.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned BCWIDTH   = 3
) (
    input  logic                     Clk,
    input  logic                     RstN,
    input  logic                     ClrN,
    input  logic [NREQ-1:0]          Req_N,
    input  logic [NREQ*DWIDTH-1:0]   Req_Data,
    output logic [NREQ-1:0]          Gnt_N,
    output logic [NREQ-1:0]          Ack_N,
    output logic                     Busy,
    input  logic                     F_FullN,
    output logic                     FInN,
    output logic [DWIDTH-1:0]        F_DataIn
);

    localparam int unsigned IWIDTH = clog2Min1(NREQ);

    logic [0:0]         state;
    logic [NREQ-1:0]    gntN;
    logic [IWIDTH-1:0]  gntIdx;
    logic [IWIDTH-1:0]  rrLast;
    logic [BCWIDTH-1:0] burstCnt;
    logic [IWIDTH-1:0]  pickWinner;
    logic               pickValid;
    logic               reqHeld;
    logic               write;
    logic               burstEnd;
    logic               relGrant;

    fifo_rr_pick #(
        .NREQ   (NREQ),
        .IWIDTH (IWIDTH)
    ) uPick (
        .Req    (~Req_N),
        .RrLast (rrLast),
        .Winner (pickWinner),
        .Valid  (pickValid)
    );

    // gntN is all ones in IDLE, so reqHeld (and hence write) can only be true in GRANT.
    assign Busy     = (state == GRANT);
    assign reqHeld  = |(~Req_N & ~gntN);
    assign write    = Busy && reqHeld && F_FullN && ClrN;
    assign burstEnd = write && (burstCnt == BCWIDTH'(BURST_MAX - 1));
    assign relGrant = !reqHeld || burstEnd || !F_FullN;

    assign Gnt_N    = gntN;
    assign FInN     = !write;
    assign Ack_N    = gntN | {NREQ{~write}};
    assign F_DataIn = Busy ? DWIDTH'(Req_Data >> (32'(gntIdx) * DWIDTH)) : '0;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state    <= IDLE;
            gntN     <= '1;
            gntIdx   <= '0;
            burstCnt <= '0;
            rrLast   <= IWIDTH'(NREQ - 1);
        end else if (!ClrN) begin
            state    <= IDLE;
            gntN     <= '1;
            gntIdx   <= '0;
            burstCnt <= '0;
            rrLast   <= IWIDTH'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (F_FullN && pickValid) begin
                        state    <= GRANT;
                        gntN     <= ~(NREQ'(1) << pickWinner);
                        gntIdx   <= pickWinner;
                        rrLast   <= pickWinner;
                        burstCnt <= '0;
                    end
                end
                GRANT: begin
                    if (relGrant) begin
                        state    <= IDLE;
                        gntN     <= '1;
                        burstCnt <= '0;
                    end else if (write) begin
                        burstCnt <= burstCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gntN  <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a cycle-by-cycle vector table plus directed
// sequences, with written words checked against a scoreboard queue of expected data.
module tb_fifo_wr_arbiter;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        RstN;
    logic        ClrN;
    logic [1:0]  Req_N;
    logic [63:0] Req_Data;
    logic [1:0]  Gnt_N;
    logic [1:0]  Ack_N;
    logic        Busy;
    logic        F_FullN;
    logic        FInN;
    logic [31:0] F_DataIn;

    always #5 Clk = ~Clk;

    fifo_wr_arbiter #(
        .NREQ      (2),
        .DWIDTH    (32),
        .BURST_MAX (4),
        .BCWIDTH   (3)
    ) dut (
        .Clk      (Clk),
        .RstN     (RstN),
        .ClrN     (ClrN),
        .Req_N    (Req_N),
        .Req_Data (Req_Data),
        .Gnt_N    (Gnt_N),
        .Ack_N    (Ack_N),
        .Busy     (Busy),
        .F_FullN  (F_FullN),
        .FInN     (FInN),
        .F_DataIn (F_DataIn)
    );

    typedef struct {
        logic [1:0]  reqN;
        logic        fullN;
        logic [1:0]  gntN;
        logic        finN;
        logic [1:0]  ackN;
        logic        busy;
        logic [31:0] data;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] base [2];
    int          dcnt [2];
    int          fifoCnt;
    bit          readerOn;
    bit          tableMode;
    logic [31:0] expQ [$];
    logic [1:0]  sGntN, sAckN;
    logic        sFInN, sBusy;
    vec_t        vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic driveData();
        Req_Data = {base[1] + 32'(dcnt[1]), base[0] + 32'(dcnt[0])};
    endtask

    // One clock: sample at negedge, check writes, then update requester and FIFO models.
    task automatic cycle();
        bit popped;
        @(negedge Clk);
        sGntN = Gnt_N;
        sAckN = Ack_N;
        sFInN = FInN;
        sBusy = Busy;
        if (FInN == 1'b0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got data %h, required no write (t=%0t)", F_DataIn, $time);
            end else begin
                chk("write_data", F_DataIn, expQ.pop_front());
            end
            if (!tableMode) chk("no_overflow", 32'(fifoCnt < DEPTH), 32'd1);
        end
        @(posedge Clk);
        #1;
        if (sAckN[0] == 1'b0) dcnt[0]++;
        if (sAckN[1] == 1'b0) dcnt[1]++;
        popped  = readerOn && (fifoCnt > 0);
        fifoCnt = fifoCnt + ((sFInN == 1'b0) ? 1 : 0) - (popped ? 1 : 0);
        driveData();
        if (!tableMode) F_FullN = (fifoCnt < DEPTH);
    endtask

    task automatic doReset();
        RstN      = 1'b0;
        ClrN      = 1'b1;
        Req_N     = 2'b11;
        readerOn  = 1'b1;
        tableMode = 1'b0;
        fifoCnt   = 0;
        dcnt[0]   = 0;
        dcnt[1]   = 0;
        driveData();
        F_FullN   = 1'b1;
        repeat (2) @(posedge Clk);
        #1 RstN = 1'b1;
    endtask

    task automatic endTest(input string name);
        Req_N = 2'b11;
        repeat (3) cycle();
        chk({name, "_queue_drained"}, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;

        vecs[0] = '{2'b11, 1'b1, 2'b11, 1'b1, 2'b11, 1'b0, 32'h0};
        vecs[1] = '{2'b10, 1'b1, 2'b11, 1'b1, 2'b11, 1'b0, 32'h0};
        vecs[2] = '{2'b10, 1'b1, 2'b10, 1'b0, 2'b10, 1'b1, 32'h1000_0000};
        vecs[3] = '{2'b10, 1'b0, 2'b10, 1'b1, 2'b11, 1'b1, 32'h0};
        vecs[4] = '{2'b00, 1'b0, 2'b11, 1'b1, 2'b11, 1'b0, 32'h0};
        vecs[5] = '{2'b00, 1'b1, 2'b11, 1'b1, 2'b11, 1'b0, 32'h0};
        vecs[6] = '{2'b11, 1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 32'h0};
        vecs[7] = '{2'b01, 1'b1, 2'b11, 1'b1, 2'b11, 1'b0, 32'h0};
        vecs[8] = '{2'b01, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 32'h2000_0000};

        // Reset outputs with both requesting, then requester 0 wins first.
        base[0] = 32'h3000_0000;
        base[1] = 32'h4000_0000;
        doReset();
        RstN  = 1'b0;
        Req_N = 2'b00;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_gnt", 32'(Gnt_N), 32'h3);
        chk("rst_fin", 32'(FInN), 32'h1);
        chk("rst_ack", 32'(Ack_N), 32'h3);
        chk("rst_busy", 32'(Busy), 32'h0);
        RstN = 1'b1;
        expQ.push_back(32'h3000_0000);
        cycle();
        chk("t1_idle_gnt", 32'(sGntN), 32'h3);
        cycle();
        chk("t1_first_gnt", 32'(sGntN), 32'h2);
        endTest("t1");

        // Cycle-level vector table with F_FullN driven directly.
        base[0] = 32'h1000_0000;
        base[1] = 32'h2000_0000;
        doReset();
        tableMode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            Req_N   = vecs[i].reqN;
            F_FullN = vecs[i].fullN;
            if (vecs[i].finN == 1'b0) expQ.push_back(vecs[i].data);
            cycle();
            chk($sformatf("vec%0d_gnt", i), 32'(sGntN), 32'(vecs[i].gntN));
            chk($sformatf("vec%0d_fin", i), 32'(sFInN), 32'(vecs[i].finN));
            chk($sformatf("vec%0d_ack", i), 32'(sAckN), 32'(vecs[i].ackN));
            chk($sformatf("vec%0d_busy", i), 32'(sBusy), 32'(vecs[i].busy));
        end
        tableMode = 1'b0;
        endTest("table");

        // Single requester held: burst of 4, one idle cycle, re-grant resumes the data stream.
        base[0] = 32'hA0;
        base[1] = 32'h0;
        doReset();
        for (int w = 0; w < 8; w++) expQ.push_back(32'hA0 + 32'(w));
        Req_N = 2'b10;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i == 1) chk("t2_gnt_c1", 32'(sGntN), 32'h2);
            if (i == 5) chk("t2_idle_c5", 32'(sGntN), 32'h3);
            if (i == 6) chk("t2_regnt_c6", 32'(sGntN), 32'h2);
        end
        endTest("t2");

        // Both requesting: grants alternate 0,1,0,1 with an idle cycle between bursts.
        base[0] = 32'hB0;
        base[1] = 32'hC0;
        doReset();
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 4; w++)
                expQ.push_back(((b % 2) != 0 ? 32'hC0 : 32'hB0) + 32'((b / 2) * 4 + w));
        Req_N = 2'b00;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (i % 5 == 0) chk($sformatf("t3_idle_c%0d", i), 32'(sGntN), 32'h3);
            if (i % 5 == 1) chk($sformatf("t3_gnt_c%0d", i), 32'(sGntN), ((i / 5) % 2 == 0) ? 32'h2 : 32'h1);
        end
        endTest("t3");

        // Reader stopped with one word already queued: FIFO fills mid-burst.
        base[0] = 32'h0;
        base[1] = 32'hD0;
        doReset();
        readerOn = 1'b0;
        fifoCnt  = 1;
        for (int w = 0; w < 4; w++) expQ.push_back(32'hD0 + 32'(w));
        Req_N = 2'b01;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i == 4) begin
                chk("t4_full_fin", 32'(sFInN), 32'h1);
                chk("t4_full_busy", 32'(sBusy), 32'h1);
            end
            if (i >= 5) chk($sformatf("t4_no_gnt_c%0d", i), 32'(sGntN), 32'h3);
        end
        readerOn = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (sGntN == 2'b01) found = 1'b1;
        end
        chk("t4_regrant_after_pop", 32'(found), 32'h1);
        if (found) chk("t4_regrant_write", 32'(sFInN), 32'h0);
        endTest("t4");

        // Synchronous clear after two words of a requester-1 burst.
        base[0] = 32'hF0;
        base[1] = 32'hE0;
        doReset();
        expQ.push_back(32'hE0);
        expQ.push_back(32'hE1);
        expQ.push_back(32'hF0);
        Req_N = 2'b01;
        repeat (3) cycle();
        ClrN = 1'b0;
        cycle();
        chk("t5_clr_fin", 32'(sFInN), 32'h1);
        chk("t5_clr_ack", 32'(sAckN), 32'h3);
        chk("t5_clr_gnt_held", 32'(sGntN), 32'h1);
        ClrN  = 1'b1;
        Req_N = 2'b00;
        cycle();
        chk("t5_after_clr_gnt", 32'(sGntN), 32'h3);
        cycle();
        chk("t5_next_gnt_req0", 32'(sGntN), 32'h2);
        chk("t5_next_write", 32'(sFInN), 32'h0);
        endTest("t5");

        // Asynchronous reset mid-burst takes effect before any clock edge.
        base[0] = 32'h50;
        base[1] = 32'h0;
        doReset();
        expQ.push_back(32'h50);
        Req_N = 2'b10;
        repeat (2) cycle();
        #2;
        chk("t6_pre_rst_fin", 32'(FInN), 32'h0);
        RstN = 1'b0;
        #1;
        chk("t6_rst_fin", 32'(FInN), 32'h1);
        chk("t6_rst_gnt", 32'(Gnt_N), 32'h3);
        chk("t6_rst_ack", 32'(Ack_N), 32'h3);
        chk("t6_rst_busy", 32'(Busy), 32'h0);
        cycle();
        RstN = 1'b1;
        endTest("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
